// File: rtl/arbitro_round_robin.sv
// arbitro_round_robin: 16-way arbiter, fixed-priority or round-robin winner selection,
// registered one-hot grant with a bounded hold time and a forced-release timeout pulse.
module arbitro_round_robin #(
    parameter int MAX_HOLD = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    input  logic        mode,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_idx,
    output logic        gnt_valid,
    output logic        timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_n;
    logic [7:0] hold, hold_n;
    logic [3:0] last_idx, last_n, fix_w, rr_w, win, idx_n;
    logic [15:0] gnt_n;
    logic valid_n, timeout_n, expire, release_c;
    // Later iterations overwrite earlier ones, so the last hit is the winner:
    // highest index for fixed priority, nearest below last_idx for round-robin.
    always_comb begin
        fix_w = '0;
        for (int i = 0; i < 16; i++) if (req[i]) fix_w = 4'(i);
        rr_w = '0;
        for (int k = 16; k >= 1; k--) if (req[last_idx - 4'(k)]) rr_w = last_idx - 4'(k);
    end
    assign win       = mode ? rr_w : fix_w;
    assign expire    = hold == 8'(MAX_HOLD);
    assign release_c = done || !req[gnt_idx] || expire;
    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        idx_n     = gnt_idx;
        valid_n   = gnt_valid;
        timeout_n = 1'b0;
        hold_n    = hold;
        last_n    = last_idx;
        if (state == IDLE) begin
            if (|req) begin
                state_n = GRANT;
                gnt_n   = 16'(1) << win;
                idx_n   = win;
                valid_n = 1'b1;
                hold_n  = '0;
                last_n  = win;
            end
        end else if (release_c) begin
            state_n   = IDLE;
            gnt_n     = '0;
            idx_n     = '0;
            valid_n   = 1'b0;
            timeout_n = expire && !done && req[gnt_idx];
        end else begin
            hold_n = hold + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold      <= '0;
            last_idx  <= '0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            gnt_idx   <= idx_n;
            gnt_valid <= valid_n;
            timeout   <= timeout_n;
            hold      <= hold_n;
            last_idx  <= last_n;
        end
    end
endmodule

// File: tb/tb_arbitro_round_robin.sv
// tb_arbitro_round_robin: directed scenarios plus random traffic, checked cycle by cycle
// against a behavioural arbiter model.
module tb_arbitro_round_robin;
    localparam int MH = 15;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic        mode;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;
    int n_chk = 0;
    int n_pass = 0;
    bit m_busy;
    int m_who, m_last, m_age;
    bit m_to;

    arbitro_round_robin #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done), .mode(mode),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int pick(input logic [15:0] r, input bit m, input int last);
        if (!m) begin
            for (int i = 15; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int s = 1; s <= 16; s++) if (r[(last - s + 16) % 16]) return (last - s + 16) % 16;
        end
        return 0;
    endfunction

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step(input bit r, input logic [15:0] q, input bit d, input bit m);
        m_to = 1'b0;
        if (r) begin
            m_busy = 0; m_who = 0; m_last = 0; m_age = 0;
        end else if (!m_busy) begin
            if (q != 0) begin
                m_who = pick(q, m, m_last);
                m_last = m_who;
                m_busy = 1;
                m_age = 0;
            end
        end else if (d || !q[m_who]) begin
            m_busy = 0;
        end else if (m_age == MH) begin
            m_busy = 0;
            m_to = 1'b1;
        end else begin
            m_age++;
        end
    endtask

    task automatic cyc(input bit r, input logic [15:0] q, input bit d, input bit m);
        rst = r; req = q; done = d; mode = m;
        model_step(r, q, d, m);
        @(posedge clk);
        #1;
        check("gnt", 32'(gnt), m_busy ? 32'(1) << m_who : 32'd0);
        check("gnt_idx", 32'(gnt_idx), m_busy ? 32'(m_who) : 32'd0);
        check("gnt_valid", 32'(gnt_valid), 32'(m_busy));
        check("timeout", 32'(timeout), 32'(m_to));
    endtask

    initial begin
        int vcnt;
        logic [15:0] rq;
        m_busy = 0; m_who = 0; m_last = 0; m_age = 0; m_to = 0;
        rst = 1; req = 0; done = 0; mode = 0;
        cyc(1, 16'h0000, 0, 0);
        cyc(1, 16'h0000, 0, 0);
        cyc(0, 16'h0000, 1, 0);
        check("idle_valid", 32'(gnt_valid), 32'd0);
        // fixed priority
        cyc(0, 16'h8421, 0, 0);
        check("fix_gnt", 32'(gnt), 32'h8000);
        check("fix_idx", 32'(gnt_idx), 32'd15);
        cyc(0, 16'h8421, 1, 0);
        check("fix_rel", 32'(gnt_valid), 32'd0);
        // round-robin rotation from reset
        cyc(1, 16'h0000, 0, 1);
        for (int g = 0; g < 4; g++) begin
            cyc(0, 16'h0006, 0, 1);
            check("rr_idx", 32'(gnt_idx), (g % 2 == 0) ? 32'd2 : 32'd1);
            cyc(0, 16'h0006, 1, 1);
            check("rr_gap", 32'(gnt_valid), 32'd0);
        end
        // timeout
        cyc(1, 16'h0000, 0, 0);
        vcnt = 0;
        for (int c = 0; c < 17; c++) begin
            cyc(0, 16'h0001, 0, 0);
            if (gnt_valid) vcnt++;
        end
        check("to_len", 32'(vcnt), 32'd16);
        check("to_pulse", 32'(timeout), 32'd1);
        cyc(0, 16'h0001, 0, 0);
        check("to_once", 32'(timeout), 32'd0);
        // done coincident with hold expiry
        cyc(1, 16'h0000, 0, 0);
        for (int c = 0; c < 16; c++) cyc(0, 16'h0001, 0, 0);
        cyc(0, 16'h0001, 1, 0);
        check("coin_rel", 32'(gnt_valid), 32'd0);
        check("coin_to", 32'(timeout), 32'd0);
        // holder drops its request
        cyc(1, 16'h0000, 0, 0);
        cyc(0, 16'h0088, 0, 0);
        check("drop_idx7", 32'(gnt_idx), 32'd7);
        cyc(0, 16'h0008, 0, 0);
        check("drop_rel", 32'(gnt_valid), 32'd0);
        cyc(0, 16'h0008, 0, 0);
        check("drop_idx3", 32'(gnt_idx), 32'd3);
        // reset mid-grant
        cyc(0, 16'h0008, 0, 0);
        cyc(0, 16'h0000, 0, 0);
        cyc(0, 16'h0010, 0, 0);
        cyc(1, 16'h0010, 0, 0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_to", 32'(timeout), 32'd0);
        cyc(0, 16'hFFFF, 0, 1);
        check("rst_rr_first", 32'(gnt_idx), 32'd15);
        // random traffic
        rq = 16'h0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) rq = 16'($urandom) & 16'($urandom);
            cyc($urandom_range(0, 99) == 0, rq, $urandom_range(0, 9) == 0, 1'($urandom));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
